// File: rtl/instr_mem_loader.sv
// Streams instruction words into the instruction memory write port from address 0.
// Optional `LOADER_CHECKSUM_EN adds a running XOR checksum output of the accepted words.
module instr_mem_loader #(
    parameter int SIZE  = 32,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [$clog2(SIZE)-1:0]  mem_addr,
    output logic [WIDTH-1:0]         mem_data,
    output logic                     mem_we,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(SIZE):0]    count,
    output logic                     full
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]         checksum
`endif
);

    localparam int AW = $clog2(SIZE);
    localparam logic [AW:0] LAST_ADDR = (AW + 1)'(SIZE - 1);
    localparam logic [AW:0] ONE       = (AW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Handshake and status decode from the registered state only.
    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD);
    assign done     = (state == DONE);

    // count doubles as the write pointer; it is reached only up to SIZE so no wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            count    <= '0;
            full     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= LOAD;
                        count <= '0;
                        full  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        mem_addr <= count[AW-1:0];
                        mem_data <= in_data;
                        mem_we   <= 1'b1;
                        count    <= count + ONE;
`ifdef LOADER_CHECKSUM_EN
                        checksum <= checksum ^ in_data;
`endif
                        if (in_last || count == LAST_ADDR) begin
                            state <= DONE;
                            full  <= ~in_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a behavioural reference checked every cycle
// plus literal expectations on memory image, pulse counts and status.
module tb_instr_mem_loader;

    localparam int SIZE  = 32;
    localparam int WIDTH = 20;
    localparam int AW    = $clog2(SIZE);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic             mem_we;
    logic             busy;
    logic             done;
    logic [AW:0]      count;
    logic             full;
`ifdef LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] checksum;
`endif

    instr_mem_loader #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .full     (full)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    logic [WIDTH-1:0] img [SIZE];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory stand-in and write pulse counter.
    always @(posedge clk) begin
        if (mem_we) begin
            img[mem_addr] <= mem_data;
            pulses <= pulses + 1;
        end
    end

    // Reference: phase 0 idle, 1 loading, 2 finished.
    int               m_phase = 0;
    int               m_cnt   = 0;
    bit               m_full  = 0;
    bit               m_we    = 0;
    int               m_addr  = 0;
    logic [WIDTH-1:0] m_data  = '0;
    logic [WIDTH-1:0] m_cks   = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_cnt = 0; m_full = 0; m_we = 0;
            m_addr = 0; m_data = '0; m_cks = '0;
        end else begin
            m_we = 0;
            if (m_phase != 1) begin
                if (start) begin
                    m_phase = 1; m_cnt = 0; m_full = 0; m_cks = '0;
                end
            end else if (in_valid) begin
                m_we = 1;
                m_addr = m_cnt;
                m_data = in_data;
                m_cks ^= in_data;
                m_cnt++;
                if (in_last || m_cnt == SIZE) begin
                    m_phase = 2;
                    m_full = !in_last;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
        chk("busy",     32'(busy),     32'(m_phase == 1));
        chk("done",     32'(done),     32'(m_phase == 2));
        chk("count",    32'(count),    32'(m_cnt));
        chk("full",     32'(full),     32'(m_full));
        chk("mem_we",   32'(mem_we),   32'(m_we));
        if (m_we) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_data", 32'(mem_data), 32'(m_data));
        end
`ifdef LOADER_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(m_cks));
`endif
    end

    task automatic drive(input bit s, input bit v, input logic [WIDTH-1:0] d, input bit l);
        @(posedge clk);
        #2;
        start = s; in_valid = v; in_data = d; in_last = l;
    endtask

    task automatic do_start();
        drive(1, 0, '0, 0);
        drive(0, 0, '0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_we", 32'(mem_we), 0);
        chk("reset_count",  32'(count), 0);
        chk("reset_ready",  32'(in_ready), 0);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Five back-to-back words, last on the fifth.
        do_start();
        @(negedge clk);
        chk("t1_busy_after_start", 32'(busy), 1);
        pulses = 0;
        for (int i = 1; i <= 5; i++) drive(0, 1, WIDTH'(i), i == 5);
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t1_done_with_last_we", 32'({done, mem_we}), 32'h3);
        chk("t1_last_addr", 32'(mem_addr), 4);
        chk("t1_last_data", 32'(mem_data), 5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) chk("t1_img", 32'(img[i]), 32'(i + 1));
        chk("t1_count", 32'(count), 5);
        chk("t1_full", 32'(full), 0);
        chk("t1_pulses", 32'(pulses), 5);

        // Start from DONE, then fill memory without in_last.
        do_start();
        @(negedge clk);
        chk("t2_count_cleared", 32'(count), 0);
        pulses = 0;
        for (int i = 0; i < SIZE; i++) drive(0, 1, WIDTH'(32'h100 + i), 0);
        drive(0, 0, '0, 0);
        @(negedge clk);
        chk("t2_full", 32'(full), 1);
        chk("t2_count", 32'(count), 32);
        chk("t2_ready_low", 32'(in_ready), 0);
        drive(0, 1, WIDTH'(32'hABC), 0);
        drive(0, 0, '0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t2_pulses", 32'(pulses), 32);
        chk("t2_img0", 32'(img[0]), 32'h100);
        chk("t2_img31", 32'(img[31]), 32'h11F);

        // Gapped valid: 1,0,0,1,1,0,1(last).
        do_start();
        @(negedge clk);
        chk("t3_full_cleared", 32'(full), 0);
        pulses = 0;
        drive(0, 1, WIDTH'(32'h11), 0);
        drive(0, 0, WIDTH'(32'hEEE), 0);
        drive(0, 0, WIDTH'(32'hEEE), 0);
        drive(0, 1, WIDTH'(32'h22), 0);
        drive(0, 1, WIDTH'(32'h33), 0);
        drive(0, 0, WIDTH'(32'hEEE), 1);
        drive(0, 1, WIDTH'(32'h44), 1);
        drive(0, 0, '0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t3_pulses", 32'(pulses), 4);
        chk("t3_img0", 32'(img[0]), 32'h11);
        chk("t3_img1", 32'(img[1]), 32'h22);
        chk("t3_img2", 32'(img[2]), 32'h33);
        chk("t3_img3", 32'(img[3]), 32'h44);
        chk("t3_count", 32'(count), 4);

        // Reset mid-load after three words.
        do_start();
        for (int i = 0; i < 3; i++) drive(0, 1, WIDTH'(32'h50 + i), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t4_we_async", 32'(mem_we), 0);
        chk("t4_busy_async", 32'(busy), 0);
        chk("t4_count_async", 32'(count), 0);
        chk("t4_addr_async", 32'(mem_addr), 0);
        @(posedge clk);
        #2 reset = 1'b1;
        do_start();
        drive(0, 1, WIDTH'(32'h77), 0);
        drive(1, 0, '0, 0);
        @(negedge clk);
        chk("t4_count_first", 32'(count), 1);
        chk("t4_addr_first", 32'(mem_addr), 0);
        drive(0, 1, WIDTH'(32'h78), 1);
        drive(0, 0, '0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t4_count_final", 32'(count), 2);
        chk("t4_img0", 32'(img[0]), 32'h77);
        chk("t4_img1", 32'(img[1]), 32'h78);

`ifdef LOADER_CHECKSUM_EN
        do_start();
        drive(0, 1, WIDTH'(32'h0000F), 0);
        drive(0, 1, WIDTH'(32'h000F0), 0);
        drive(0, 1, WIDTH'(32'h00FF0), 1);
        drive(0, 0, '0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5_checksum", 32'(checksum), 32'h00F0F);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
